// File: rtl/vga_timing_gen.sv
// ---------------------------------------------------------------------------
// vga_timing_gen
//
// Raster timing generator for a VGA pixel pipeline. It scans an
// H_TOTAL x V_TOTAL frame (default 800x525, visible 640x480) and produces
// registered pixel coordinates, a display-enable flag and active-low sync
// pulses. The syncs are held back by SYNC_DELAY pixel ticks so that they
// line up with the registered ROM-lookup latency of the pixel renderer.
//
// Optional feature macro: VGA_PIXEL_DIV_EN
//   defined   : pixel_tick comes from a 0..PIX_DIV-1 clock divider
//   undefined : pixel_tick is tied high and the counters advance every clk
//
// Ports:
//   clk         in   system clock
//   rst_n       in   synchronous, active-low reset
//   x           out  horizontal counter, 0..H_TOTAL-1
//   y           out  vertical counter,   0..V_TOTAL-1
//   display_en  out  high while x < H_ACTIVE and y < V_ACTIVE
//   hsync       out  active-low horizontal sync, SYNC_DELAY ticks late
//   vsync       out  active-low vertical sync,   SYNC_DELAY ticks late
//   pixel_tick  out  counter-advance strobe
//   frame_start out  one-clk pulse on the first clk at (0,0)
// ---------------------------------------------------------------------------
module vga_timing_gen #(
  parameter int H_ACTIVE         = 640,
  parameter int H_FP             = 16,
  parameter int H_SYNC           = 96,
  parameter int H_BP             = 48,
  parameter int V_ACTIVE         = 480,
  parameter int V_FP             = 10,
  parameter int V_SYNC           = 2,
  parameter int V_BP             = 33,
  parameter int SYNC_DELAY       = 2,
  parameter int PIX_DIV          = 4,
  parameter int COORDINATE_WIDTH = 10
) (
  input  logic                        clk,
  input  logic                        rst_n,
  output logic [COORDINATE_WIDTH-1:0] x,
  output logic [COORDINATE_WIDTH-1:0] y,
  output logic                        display_en,
  output logic                        hsync,
  output logic                        vsync,
  output logic                        pixel_tick,
  output logic                        frame_start
);

  localparam int CW      = COORDINATE_WIDTH;
  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

  localparam logic [CW-1:0] H_LAST     = CW'(H_TOTAL - 1);
  localparam logic [CW-1:0] V_LAST     = CW'(V_TOTAL - 1);
  localparam logic [CW-1:0] H_ACT_LIM  = CW'(H_ACTIVE);
  localparam logic [CW-1:0] V_ACT_LIM  = CW'(V_ACTIVE);
  localparam logic [CW-1:0] HS_START   = CW'(H_ACTIVE + H_FP);
  localparam logic [CW-1:0] HS_END     = CW'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [CW-1:0] VS_START   = CW'(V_ACTIVE + V_FP);
  localparam logic [CW-1:0] VS_END     = CW'(V_ACTIVE + V_FP + V_SYNC);

  // Elaboration-time parameter legality checks.
  if (SYNC_DELAY < 0 || SYNC_DELAY > 7) begin : g_bad_sync_delay
    $error("vga_timing_gen: SYNC_DELAY must be within 0..7");
  end
  if (PIX_DIV < 2) begin : g_bad_pix_div
    $error("vga_timing_gen: PIX_DIV must be at least 2");
  end
  if (H_TOTAL > (1 << CW) || V_TOTAL > (1 << CW)) begin : g_bad_width
    $error("vga_timing_gen: COORDINATE_WIDTH too small for the frame size");
  end

  // -------------------------------------------------------------------------
  // Pixel tick
  // -------------------------------------------------------------------------
  logic tick;

`ifdef VGA_PIXEL_DIV_EN
  localparam int              DIV_W    = $clog2(PIX_DIV);
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(PIX_DIV - 1);

  logic [DIV_W-1:0] div_q;
  logic [DIV_W-1:0] div_d;

  always_comb begin
    tick  = (div_q == DIV_LAST);
    div_d = tick ? '0 : div_q + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      div_q <= '0;
    end else begin
      div_q <= div_d;
    end
  end
`else
  assign tick = 1'b1;
`endif

  assign pixel_tick = tick;

  // -------------------------------------------------------------------------
  // Counters, display enable, frame start and sync pipelines
  // -------------------------------------------------------------------------
  logic [CW-1:0]       x_q, x_d;
  logic [CW-1:0]       y_q, y_d;
  logic                de_q, de_d;
  logic                fs_q, fs_d;
  // Stage 0 holds the decode of the current counters; each further stage
  // adds one tick of delay, so the last stage is SYNC_DELAY ticks late.
  logic [SYNC_DELAY:0] hs_pipe_q, hs_pipe_d;
  logic [SYNC_DELAY:0] vs_pipe_q, vs_pipe_d;

  always_comb begin
    x_d       = x_q;
    y_d       = y_q;
    de_d      = de_q;
    fs_d      = 1'b0;
    hs_pipe_d = hs_pipe_q;
    vs_pipe_d = vs_pipe_q;

    if (tick) begin
      if (x_q == H_LAST) begin
        x_d = '0;
        y_d = (y_q == V_LAST) ? '0 : y_q + 1'b1;
      end else begin
        x_d = x_q + 1'b1;
      end

      // Flags are decoded from the next counter values so they are
      // registered alongside x/y rather than lagging them by one tick.
      de_d = (x_d < H_ACT_LIM) && (y_d < V_ACT_LIM);
      fs_d = (x_d == '0) && (y_d == '0);

      // y only changes when x wraps, so vsync naturally moves at x=0.
      hs_pipe_d[0] = !((x_d >= HS_START) && (x_d < HS_END));
      vs_pipe_d[0] = !((y_d >= VS_START) && (y_d < VS_END));
      for (int i = 1; i <= SYNC_DELAY; i++) begin
        hs_pipe_d[i] = hs_pipe_q[i-1];
        vs_pipe_d[i] = vs_pipe_q[i-1];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      // Parked on the last pixel so the first tick wraps into a new frame.
      x_q       <= H_LAST;
      y_q       <= V_LAST;
      de_q      <= 1'b0;
      fs_q      <= 1'b0;
      hs_pipe_q <= '1;
      vs_pipe_q <= '1;
    end else begin
      x_q       <= x_d;
      y_q       <= y_d;
      de_q      <= de_d;
      fs_q      <= fs_d;
      hs_pipe_q <= hs_pipe_d;
      vs_pipe_q <= vs_pipe_d;
    end
  end

  assign x           = x_q;
  assign y           = y_q;
  assign display_en  = de_q;
  assign frame_start = fs_q;
  assign hsync       = hs_pipe_q[SYNC_DELAY];
  assign vsync       = vs_pipe_q[SYNC_DELAY];

endmodule

// File: tb/tb_vga_timing_gen.sv
// ---------------------------------------------------------------------------
// tb_vga_timing_gen
//
// Randomized bench for vga_timing_gen using a reduced frame geometry so
// several whole frames fit in a short run. Two instances are checked every
// clk: SYNC_DELAY=2 and SYNC_DELAY=0. Expected outputs come from a model
// that derives the raster position arithmetically from the number of clks
// since reset release.
// ---------------------------------------------------------------------------
module tb_vga_timing_gen;

  localparam int HA = 16, HF = 4, HS = 6, HB = 5;
  localparam int VA = 10, VF = 2, VS = 2, VB = 3;
  localparam int HT = HA + HF + HS + HB;   // 31
  localparam int VT = VA + VF + VS + VB;   // 17
  localparam int FRAME = HT * VT;          // 527
  localparam int PDIV = 4;
  localparam int CW = 10;

`ifdef VGA_PIXEL_DIV_EN
  localparam int DIVF = PDIV;
`else
  localparam int DIVF = 1;
`endif

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [CW-1:0] x2, y2, x0, y0;
  logic          de2, hs2, vs2, tk2, fs2;
  logic          de0, hs0, vs0, tk0, fs0;

  always #5 clk = ~clk;

  vga_timing_gen #(
    .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
    .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VS), .V_BP(VB),
    .SYNC_DELAY(2), .PIX_DIV(PDIV), .COORDINATE_WIDTH(CW)
  ) u_dut_d2 (
    .clk(clk), .rst_n(rst_n), .x(x2), .y(y2), .display_en(de2),
    .hsync(hs2), .vsync(vs2), .pixel_tick(tk2), .frame_start(fs2)
  );

  vga_timing_gen #(
    .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
    .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VS), .V_BP(VB),
    .SYNC_DELAY(0), .PIX_DIV(PDIV), .COORDINATE_WIDTH(CW)
  ) u_dut_d0 (
    .clk(clk), .rst_n(rst_n), .x(x0), .y(y0), .display_en(de0),
    .hsync(hs0), .vsync(vs0), .pixel_tick(tk0), .frame_start(fs0)
  );

  int vectors = 0;
  int miscompares = 0;

  task automatic chk(input string tag, input int got, input int exp);
    vectors++;
    if (got != exp) begin
      miscompares++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference model: c = clks since reset release (0 while in reset).
  task automatic model(input int c, input int d,
                       output int ex, output int ey, output int ede,
                       output int ehs, output int evs, output int efs,
                       output int etk);
    int n, k, j, hx, hy;
    n = c / DIVF;                     // pixel ticks completed
    etk = (DIVF == 1) ? 1 : ((c % DIVF) == DIVF - 1);
    if (n == 0) begin
      ex = HT - 1; ey = VT - 1; ede = 0; ehs = 1; evs = 1; efs = 0;
    end else begin
      k   = n - 1;                    // index of the current pixel
      ex  = k % HT;
      ey  = (k / HT) % VT;
      ede = (ex < HA) && (ey < VA);
      efs = ((k % FRAME) == 0) && ((c % DIVF) == 0);
      j   = k - d;                    // pixel whose sync decode is shown
      if (j < 0) begin
        ehs = 1; evs = 1;
      end else begin
        hx  = j % HT;
        hy  = (j / HT) % VT;
        ehs = !((hx >= HA + HF) && (hx < HA + HF + HS));
        evs = !((hy >= VA + VF) && (hy < VA + VF + VS));
      end
    end
  endtask

  int  clk_cnt = 0;
  bit  model_valid = 1'b0;

  always @(posedge clk) begin
    if (!rst_n) begin
      clk_cnt     <= 0;
      model_valid <= 1'b1;
    end else begin
      clk_cnt <= clk_cnt + 1;
    end
  end

  always @(negedge clk) begin
    int ex, ey, ede, ehs, evs, efs, etk;
    if (model_valid) begin
      model(clk_cnt, 2, ex, ey, ede, ehs, evs, efs, etk);
      chk("d2_x", int'(x2), ex);
      chk("d2_y", int'(y2), ey);
      chk("d2_display_en", int'(de2), ede);
      chk("d2_hsync", int'(hs2), ehs);
      chk("d2_vsync", int'(vs2), evs);
      chk("d2_frame_start", int'(fs2), efs);
      chk("d2_pixel_tick", int'(tk2), etk);
      model(clk_cnt, 0, ex, ey, ede, ehs, evs, efs, etk);
      chk("d0_x", int'(x0), ex);
      chk("d0_y", int'(y0), ey);
      chk("d0_display_en", int'(de0), ede);
      chk("d0_hsync", int'(hs0), ehs);
      chk("d0_vsync", int'(vs0), evs);
      chk("d0_frame_start", int'(fs0), efs);
      chk("d0_pixel_tick", int'(tk0), etk);
    end
  end

  initial begin
    int rst_len, run_len;
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    for (int seg = 0; seg < 14; seg++) begin
      rst_len = int'($urandom_range(1, 3));
      if (seg == 0)
        run_len = 2 * FRAME * DIVF + 50;       // two full frames and a bit
      else
        run_len = int'($urandom_range(20, 1500)) * DIVF / 2 + 1;
      rst_n = 1'b0;
      repeat (rst_len) @(negedge clk);
      rst_n = 1'b1;
      repeat (run_len) @(negedge clk);
      $display("segment %0d: reset %0d clks, run %0d clks, total vectors %0d, miscompares %0d",
               seg, rst_len, run_len, vectors, miscompares);
    end
    @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
